approx_error_scanner: RTL and testbench

//  Exhaustive error-evaluation sequencer for a synthesized approximate circuit.
//  - Drives every input vector 0..2^N_IN-1 into an exact and an approximate

---
 rtl/approx_error_scanner_if.sv | 29 ++
 rtl/approx_error_scanner.sv | 107 ++++++++++
 tb/tb_approx_error_scanner.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/approx_error_scanner_if.sv
// Bundle between the error scanner and the exact/approximate circuit harness.
// The master side drives control and the circuit outputs; the slave side is the scanner.
interface approx_error_scanner_if #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned W_OUT = 3
);
  logic              start;
  logic              abort;
  logic [N_IN-1:0]   vec_out;
  logic [W_OUT-1:0]  exact_in;
  logic [W_OUT-1:0]  approx_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [W_OUT-1:0]  max_err;
  logic [N_IN:0]     err_count;
  logic              fail_seen;
  logic [N_IN-1:0]   fail_vec;

  modport master (
    output start, abort, exact_in, approx_in,
    input  vec_out, busy, done, pass, max_err, err_count, fail_seen, fail_vec
  );

  modport slave (
    input  start, abort, exact_in, approx_in,
    output vec_out, busy, done, pass, max_err, err_count, fail_seen, fail_vec
  );
endinterface

// File: rtl/approx_error_scanner.sv
// Walks every input vector through an exact and an approximate circuit and
// accumulates max |error|, count of erroneous vectors and first threshold violation.
module approx_error_scanner #(
  parameter int unsigned N_IN         = 4,
  parameter int unsigned W_OUT        = 3,
  parameter int unsigned ET           = 3,
  parameter int unsigned STOP_ON_FAIL = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  approx_error_scanner_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic [N_IN-1:0]  vec_q, vec_nx, fvec_q, fvec_nx;
  logic [W_OUT-1:0] max_q, max_nx, err;
  logic [N_IN:0]    cnt_q, cnt_nx;
  logic             fseen_q, fseen_nx, pass_q, pass_nx;
  logic             over_et, first_fail;

  always_comb begin
    err        = (bus.exact_in >= bus.approx_in) ? bus.exact_in - bus.approx_in
                                                 : bus.approx_in - bus.exact_in;
    over_et    = 32'(err) > ET;
    first_fail = over_et && !fseen_q;

    state_nx = state;
    vec_nx   = vec_q;
    max_nx   = max_q;
    cnt_nx   = cnt_q;
    fseen_nx = fseen_q;
    fvec_nx  = fvec_q;
    pass_nx  = pass_q;

    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = SCAN;
          vec_nx   = '0;
          max_nx   = '0;
          cnt_nx   = '0;
          fseen_nx = 1'b0;
          fvec_nx  = '0;
          pass_nx  = 1'b0;
        end
      end
      SCAN: begin
        // an aborting edge leaves the partial results exactly as they were
        if (bus.abort) begin
          state_nx = IDLE;
          pass_nx  = 1'b0;
        end else begin
          if (err > max_q) max_nx = err;
          if (err != '0)   cnt_nx = cnt_q + (N_IN+1)'(1);
          if (first_fail) begin
            fseen_nx = 1'b1;
            fvec_nx  = vec_q;
          end
          // vec_out freezes on the final (or first failing) vector
          if (vec_q == '1 || (STOP_ON_FAIL != 0 && first_fail)) begin
            state_nx = DONE;
            pass_nx  = 32'(max_nx) <= ET;
          end else begin
            vec_nx = vec_q + N_IN'(1);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (bus.abort) pass_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      vec_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
      fseen_q <= 1'b0;
      fvec_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      vec_q   <= vec_nx;
      max_q   <= max_nx;
      cnt_q   <= cnt_nx;
      fseen_q <= fseen_nx;
      fvec_q  <= fvec_nx;
      pass_q  <= pass_nx;
    end
  end

  assign bus.vec_out   = vec_q;
  assign bus.busy      = (state == SCAN);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_q;
  assign bus.max_err   = max_q;
  assign bus.err_count = cnt_q;
  assign bus.fail_seen = fseen_q;
  assign bus.fail_vec  = fvec_q;

endmodule

// File: tb/tb_approx_error_scanner.sv
// Bench for approx_error_scanner: two instances (run-to-end and stop-on-fail)
// driven from shared lookup tables, checked every cycle against a prefix-aggregate model.
module tb_approx_error_scanner;
  localparam int unsigned N_IN  = 4;
  localparam int unsigned W_OUT = 3;
  localparam int unsigned ET    = 3;
  localparam int          NV    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [W_OUT-1:0] exact_tab  [NV];
  logic [W_OUT-1:0] approx_tab [NV];

  always #5 clk = ~clk;

  approx_error_scanner_if #(.N_IN(N_IN), .W_OUT(W_OUT)) if0 ();
  approx_error_scanner_if #(.N_IN(N_IN), .W_OUT(W_OUT)) if1 ();

  assign if0.start     = start;
  assign if0.abort     = abort;
  assign if0.exact_in  = exact_tab[if0.vec_out];
  assign if0.approx_in = approx_tab[if0.vec_out];
  assign if1.start     = start;
  assign if1.abort     = abort;
  assign if1.exact_in  = exact_tab[if1.vec_out];
  assign if1.approx_in = approx_tab[if1.vec_out];

  approx_error_scanner #(.N_IN(N_IN), .W_OUT(W_OUT), .ET(ET), .STOP_ON_FAIL(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  approx_error_scanner #(.N_IN(N_IN), .W_OUT(W_OUT), .ET(ET), .STOP_ON_FAIL(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Model: per instance a phase, the number of vectors accumulated so far and
  // a snapshot of per-vector errors; results are aggregates over that prefix.
  int m_phase [2];   // 0 idle, 1 scanning, 2 done
  int m_n     [2];
  int m_vec   [2];
  int m_pass  [2];
  int snap_err [2][NV];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  function automatic int err_of(input int e, input int a);
    return (e > a) ? e - a : a - e;
  endfunction

  function automatic int max_of(input int d);
    int m = 0;
    for (int i = 0; i < m_n[d]; i++) if (snap_err[d][i] > m) m = snap_err[d][i];
    return m;
  endfunction

  function automatic int cnt_of(input int d);
    int c = 0;
    for (int i = 0; i < m_n[d]; i++) if (snap_err[d][i] != 0) c++;
    return c;
  endfunction

  function automatic int first_fail(input int d);
    for (int i = 0; i < m_n[d]; i++) if (snap_err[d][i] > int'(ET)) return i;
    return -1;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_n[d] = 0; m_vec[d] = 0; m_pass[d] = 0;
      for (int i = 0; i < NV; i++) snap_err[d][i] = 0;
    end
  end

  always @(posedge clk) begin : model
    bit newfail;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_phase[d] = 0; m_n[d] = 0; m_vec[d] = 0; m_pass[d] = 0;
      end else if (m_phase[d] == 0) begin
        if (start && !abort) begin
          m_phase[d] = 1; m_n[d] = 0; m_vec[d] = 0; m_pass[d] = 0;
          for (int i = 0; i < NV; i++)
            snap_err[d][i] = err_of(int'(exact_tab[i]), int'(approx_tab[i]));
        end
      end else if (m_phase[d] == 1) begin
        if (abort) begin
          m_phase[d] = 0; m_pass[d] = 0;
        end else begin
          newfail = (snap_err[d][m_vec[d]] > int'(ET)) && (first_fail(d) < 0);
          m_n[d] = m_n[d] + 1;
          if (m_vec[d] == NV - 1 || (d == 1 && newfail)) begin
            m_phase[d] = 2;
            m_pass[d]  = (max_of(d) <= int'(ET)) ? 1 : 0;
          end else begin
            m_vec[d] = m_vec[d] + 1;
          end
        end
      end else begin
        m_phase[d] = 0;
        if (abort) m_pass[d] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(input int d, input logic [31:0] vec, input logic [31:0] busy,
                         input logic [31:0] done, input logic [31:0] pass,
                         input logic [31:0] mx, input logic [31:0] cnt,
                         input logic [31:0] fs, input logic [31:0] fv);
    int ff;
    ff = first_fail(d);
    chk($sformatf("d%0d vec_out", d),   vec,  m_vec[d]);
    chk($sformatf("d%0d busy", d),      busy, int'(m_phase[d] == 1));
    chk($sformatf("d%0d done", d),      done, int'(m_phase[d] == 2));
    chk($sformatf("d%0d pass", d),      pass, m_pass[d]);
    chk($sformatf("d%0d max_err", d),   mx,   max_of(d));
    chk($sformatf("d%0d err_count", d), cnt,  cnt_of(d));
    chk($sformatf("d%0d fail_seen", d), fs,   int'(ff >= 0));
    chk($sformatf("d%0d fail_vec", d),  fv,   (ff >= 0) ? ff : 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut(0, 32'(if0.vec_out), 32'(if0.busy), 32'(if0.done), 32'(if0.pass),
              32'(if0.max_err), 32'(if0.err_count), 32'(if0.fail_seen), 32'(if0.fail_vec));
      cmp_dut(1, 32'(if1.vec_out), 32'(if1.busy), 32'(if1.done), 32'(if1.pass),
              32'(if1.max_err), 32'(if1.err_count), 32'(if1.fail_seen), 32'(if1.fail_vec));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Pulses start, then counts edges until each instance shows done (-1 if never).
  task automatic scan_and_time(output int e0, output int e1);
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = -1;
    e1 = -1;
    for (int k = 1; k <= 40 && (e0 < 0 || e1 < 0); k++) begin
      tick();
      if (if0.done && e0 < 0) e0 = k;
      if (if1.done && e1 < 0) e1 = k;
    end
    tick();
  endtask

  task automatic fill_equal;
    for (int i = 0; i < NV; i++) begin
      exact_tab[i]  = W_OUT'($urandom_range(0, 7));
      approx_tab[i] = exact_tab[i];
    end
  endtask

  int e0, e1;

  initial begin
    for (int i = 0; i < NV; i++) begin
      exact_tab[i] = '0;
      approx_tab[i] = '0;
    end
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    chk("reset max_err", 32'(if0.max_err), 0);
    chk("reset vec_out", 32'(if1.vec_out), 0);
    chk("reset busy", 32'(if0.busy), 0);

    // identical circuits
    fill_equal();
    scan_and_time(e0, e1);
    chk("A edges d0", 32'(e0), 16);
    chk("A edges d1", 32'(e1), 16);
    chk("A pass", 32'(if0.pass), 1);
    chk("A err_count", 32'(if0.err_count), 0);

    // error of 1 everywhere
    for (int i = 0; i < NV; i++) approx_tab[i] = exact_tab[i] ^ 3'b001;
    scan_and_time(e0, e1);
    chk("B err_count", 32'(if0.err_count), 16);
    chk("B max_err", 32'(if0.max_err), 1);
    chk("B pass", 32'(if0.pass), 1);
    chk("B model count", 32'(cnt_of(0)), 16);

    // single error of 4 at vector 9
    fill_equal();
    exact_tab[9]  = 3'd5;
    approx_tab[9] = 3'd1;
    scan_and_time(e0, e1);
    chk("C edges d0", 32'(e0), 16);
    chk("C edges d1", 32'(e1), 10);
    chk("C max_err", 32'(if0.max_err), 4);
    chk("C err_count", 32'(if0.err_count), 1);
    chk("C fail_seen", 32'(if0.fail_seen), 1);
    chk("C fail_vec d0", 32'(if0.fail_vec), 9);
    chk("C pass", 32'(if0.pass), 0);
    chk("C fail_vec d1", 32'(if1.fail_vec), 9);
    chk("C vec_out d1", 32'(if1.vec_out), 9);
    chk("C model first", 32'(first_fail(1)), 9);

    // abort at vector 5, then restart
    for (int i = 0; i < NV; i++) approx_tab[i] = exact_tab[i] ^ 3'b010;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20 && if0.vec_out != 4'd5; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("D busy after abort", 32'(if0.busy), 0);
    chk("D held vec", 32'(if0.vec_out), 5);
    chk("D held count", 32'(if0.err_count), 5);
    tick();
    chk("D no done", 32'(if0.done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("D restart vec", 32'(if0.vec_out), 0);
    chk("D restart count", 32'(if0.err_count), 0);
    for (int k = 0; k < 40 && !if0.done; k++) tick();
    chk("D restart done", 32'(if0.done), 1);
    tick();

    // start held through the scan, reset at vector 7
    start = 1'b1;
    tick();
    for (int k = 0; k < 20 && if0.vec_out != 4'd7; k++) tick();
    chk("E still scanning", 32'(if0.busy), 1);
    rst_n = 1'b0;
    tick();
    start = 1'b0;
    chk("E reset vec", 32'(if0.vec_out), 0);
    chk("E reset count", 32'(if0.err_count), 0);
    chk("E reset busy", 32'(if0.busy), 0);
    rst_n = 1'b1;
    tick();

    // start with abort in idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("F stays idle d0", 32'(if0.busy), 0);
    chk("F stays idle d1", 32'(if1.busy), 0);
    tick();

    // randomized traffic
    for (int c = 0; c < 900; c++) begin
      if (m_phase[0] == 0 && m_phase[1] == 0 && $urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NV; i++) begin
          exact_tab[i] = W_OUT'($urandom_range(0, 7));
          if ($urandom_range(0, 2) == 0) approx_tab[i] = W_OUT'($urandom_range(0, 7));
          else approx_tab[i] = exact_tab[i];
        end
      end
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 29) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
